cf_mem_wb: RTL

- Memory/write-back stage directly downstream of the fetch-decode-execute datapath.
- Consumes the ALU result, opcode, zero flag, rt store data and destination register from the execute stage.
- Performs word loads and stores against an internal data memory that has configurable wait states.
- Returns write-back data, destination and enable to the register bank, and applies a ready/stall handshake to the upstream stage.

---
 rtl/cf_mem_wb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cf_mem_wb.sv
// Memory/write-back stage: word loads/stores with MEM_LAT wait states and a one-cycle WB pulse.
// Optional build macro MISALIGN_TRAP_EN traps lw/sw whose byte address is not word aligned.
module cf_mem_wb #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        clk_MW,
    input  logic        rstn_MW,
    input  logic        valid_MW,
    output logic        ready_MW,
    input  logic [31:0] res_MW,
    input  logic [5:0]  op_MW,
    input  logic        zf_MW,
    input  logic [31:0] rtData_MW,
    input  logic [4:0]  wrReg_MW,
    output logic        wbEn_MW,
    output logic [4:0]  wbReg_MW,
    output logic [31:0] wbData_MW,
    output logic        brTaken_MW,
    output logic        err_MW
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    state_t              state;
    logic [5:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         rt_q;
    logic [4:0]          wr_q;
    logic [3:0]          cnt;

    logic [31:0] dataBank [0:(1<<ADDR_W)-1];

    logic xfer;
    logic in_mem;
    logic in_trap;
    logic mem_we;

    assign xfer   = valid_MW && ready_MW;
    assign in_mem = (op_MW == OP_LW) || (op_MW == OP_SW);
`ifdef MISALIGN_TRAP_EN
    assign in_trap = in_mem && (res_MW[1:0] != 2'b00);
`else
    assign in_trap = 1'b0;
`endif
    // The store commits on the last ACCESS edge; an async reset drops state to IDLE first.
    assign mem_we = (state == ACCESS) && (cnt == 4'd0) && (op_q == OP_SW);

    always_ff @(posedge clk_MW or negedge rstn_MW) begin
        if (!rstn_MW) begin
            state      <= IDLE;
            ready_MW   <= 1'b1;
            wbEn_MW    <= 1'b0;
            wbReg_MW   <= 5'd0;
            wbData_MW  <= 32'd0;
            brTaken_MW <= 1'b0;
            err_MW     <= 1'b0;
            op_q       <= 6'd0;
            addr_q     <= '0;
            rt_q       <= 32'd0;
            wr_q       <= 5'd0;
            cnt        <= 4'd0;
        end else begin
            // NOTE: pulses default low each edge with non-blocking assignments; later
            // assignments in the same block override, and every reader sees pre-edge values.
            wbEn_MW    <= 1'b0;
            brTaken_MW <= 1'b0;
            err_MW     <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        op_q     <= op_MW;
                        addr_q   <= res_MW[ADDR_W+1:2];
                        rt_q     <= rtData_MW;
                        wr_q     <= wrReg_MW;
                        ready_MW <= 1'b0;
                        if (in_mem && !in_trap) begin
                            state <= ACCESS;
                            cnt   <= CNT_INIT;
                        end else begin
                            state  <= WB;
                            err_MW <= in_trap;
                            case (op_MW)
                                OP_R, OP_ADDI: begin
                                    wbEn_MW   <= 1'b1;
                                    wbReg_MW  <= wrReg_MW;
                                    wbData_MW <= res_MW;
                                end
                                OP_BEQ:  brTaken_MW <= zf_MW;
                                default: ;
                            endcase
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= WB;
                        if (op_q == OP_LW) begin
                            wbEn_MW   <= 1'b1;
                            wbReg_MW  <= wr_q;
                            wbData_MW <= dataBank[addr_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WB: begin
                    state    <= IDLE;
                    ready_MW <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ready_MW <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the data memory has no reset; its contents survive rstn_MW by design.
    always_ff @(posedge clk_MW) begin
        if (mem_we) dataBank[addr_q] <= rt_q;
    end

endmodule
